// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Multi-cycle multiply/divide engine for the execute stage. It takes the
// decoder's 2-bit mult/div opcode and two 32-bit GPR operands, and it
// produces a 64-bit HI/LO result for the pipeline's HI/LO write logic.
// While an operation is in flight, o_busy stalls the front end.
//
// Opcodes (i_op): 2'b00 MULTU, 2'b01 MULT, 2'b10 DIVU, 2'b11 DIV
//
// Ports:
//   i_clk      clock
//   i_rst      reset, synchronous, active-low
//   i_start    launch request, sampled only in IDLE
//   i_op       operation select
//   i_src_a    rs operand (multiplicand / dividend)
//   i_src_b    rt operand (multiplier / divisor)
//   i_flush    exception/eret flush; cancels any in-flight operation
//   o_busy     operation in flight (registered)
//   o_done     one-cycle pulse; o_hi/o_lo are valid and updated this cycle
//   o_hi       MULT: product[63:32]; DIV: remainder
//   o_lo       MULT: product[31:0];  DIV: quotient
//
// Latency, counted from the accepted-start cycle T:
//   multiply: done at T+MUL_CYCLES (MUL_CYCLES legal range 2..8)
//   divide:   done at T+34. The 32 restoring iterations run from T+1 to
//             T+32, the sign fix is applied at T+33, and done is at T+34.
//
// Optional build macro MULDIV_FAST_DIV_EN: a divide whose magnitudes
// satisfy |a| < |b|, or whose divisor is zero, skips the iterations and
// pulses done at T+2.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_ITERS  = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  input  logic        i_flush,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Counter values at which the MUL and DIV states are left.
  localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 2);
  localparam logic [5:0] DIV_LAST = 6'(DIV_ITERS - 1);

  logic [2:0]  r_state;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [63:0] r_prod;     // product, registered at the start cycle
  logic [31:0] r_rem;      // partial remainder
  logic [31:0] r_quo;      // dividend shifting out / quotient shifting in
  logic [31:0] r_b_mag;    // divisor magnitude
  logic [31:0] r_a_raw;    // raw dividend, returned as HI on divide-by-zero
  logic        r_sign_a;   // dividend negative (DIV only)
  logic        r_sign_b;   // divisor negative (DIV only)
  logic        r_div0;     // divisor was zero

  logic        w_op_signed;
  logic        w_op_div;
  logic [63:0] w_ext_a;
  logic [63:0] w_ext_b;
  logic [63:0] w_prod;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic        w_b_zero;
  logic        w_fast_skip;
  logic [32:0] w_shift_rem;
  logic        w_trial_ok;
  logic [31:0] w_trial_rem;
  logic [31:0] w_fix_hi;
  logic [31:0] w_fix_lo;

  assign w_op_signed = i_op[0];
  assign w_op_div    = i_op[1];

  // Sign- or zero-extend to 64 bits. The low 64 bits of the product of the
  // extended operands are then correct for both signed and unsigned cases.
  assign w_ext_a = w_op_signed ? {{32{i_src_a[31]}}, i_src_a} : {32'd0, i_src_a};
  assign w_ext_b = w_op_signed ? {{32{i_src_b[31]}}, i_src_b} : {32'd0, i_src_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Take magnitudes as unsigned values. abs(0x80000000) stays 0x80000000 and
  // is correct when it is read as unsigned.
  assign w_a_mag  = (w_op_signed && i_src_a[31]) ? (32'd0 - i_src_a) : i_src_a;
  assign w_b_mag  = (w_op_signed && i_src_b[31]) ? (32'd0 - i_src_b) : i_src_b;
  assign w_b_zero = (i_src_b == 32'd0);

`ifdef MULDIV_FAST_DIV_EN
  assign w_fast_skip = (w_a_mag < w_b_mag) || w_b_zero;
`else
  assign w_fast_skip = 1'b0;
`endif

  // One restoring step. Shift the next dividend bit into the remainder, then
  // subtract the divisor when the shifted value is large enough. The shifted
  // value needs 33 bits. The difference always fits in 32 bits because it
  // is smaller than the divisor.
  assign w_shift_rem = {r_rem, r_quo[31]};
  assign w_trial_ok  = (w_shift_rem >= {1'b0, r_b_mag});
  assign w_trial_rem = w_shift_rem[31:0] - r_b_mag;

  // Sign fix. Divide-by-zero skips the fix and returns the raw dividend.
  assign w_fix_lo = r_div0 ? 32'hFFFF_FFFF :
                    ((r_sign_a ^ r_sign_b) ? (32'd0 - r_quo) : r_quo);
  assign w_fix_hi = r_div0 ? r_a_raw :
                    (r_sign_a ? (32'd0 - r_rem) : r_rem);

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 6'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= 32'd0;
      r_lo     <= 32'd0;
      r_prod   <= 64'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_b_mag  <= 32'd0;
      r_a_raw  <= 32'd0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_div0   <= 1'b0;
    end else if (i_flush) begin
      // Cancel the operation. hi/lo keep the last completed result.
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_cnt    <= 6'd0;
            r_busy   <= 1'b1;
            r_prod   <= w_prod;
            r_b_mag  <= w_b_mag;
            r_a_raw  <= i_src_a;
            r_sign_a <= w_op_signed & i_src_a[31];
            r_sign_b <= w_op_signed & i_src_b[31];
            r_div0   <= w_b_zero;
            if (w_op_div) begin
              // On the fast path the result is already known: q=0, r=a.
              r_state <= w_fast_skip ? S_FIX : S_DIV;
              r_rem   <= w_fast_skip ? w_a_mag : 32'd0;
              r_quo   <= w_fast_skip ? 32'd0 : w_a_mag;
            end else begin
              r_state <= S_MUL;
              r_rem   <= 32'd0;
              r_quo   <= 32'd0;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end

        S_MUL: begin
          if (r_cnt == MUL_LAST) begin
            r_hi    <= r_prod[63:32];
            r_lo    <= r_prod[31:0];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_DIV: begin
          r_rem <= w_trial_ok ? w_trial_rem : w_shift_rem[31:0];
          r_quo <= {r_quo[30:0], w_trial_ok};
          if (r_cnt == DIV_LAST) begin
            r_state <= S_FIX;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end

        S_FIX: begin
          r_hi    <= w_fix_hi;
          r_lo    <= w_fix_lo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end

        S_DONE: begin
          r_done  <= 1'b0;
          r_cnt   <= 6'd0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 6'd0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed self-checking bench for muldiv_unit. Expected values are worked
// out by hand from the operation definitions. Latency is counted in cycles
// from the accepted-start cycle T.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

`ifdef MULDIV_FAST_DIV_EN
  localparam int SKIP_LAT = 2;
`else
  localparam int SKIP_LAT = 34;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  muldiv_unit #(.MUL_CYCLES(3), .DIV_ITERS(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_op    (op),
    .i_src_a (src_a),
    .i_src_b (src_b),
    .i_flush (flush),
    .o_busy  (busy),
    .o_done  (done),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drive one start pulse in the current (IDLE) cycle T. On return the bench
  // is in cycle T+1.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    tick();
    cyc   = 1;
    start = 1'b0;
    op    = 2'b00;
    src_a = 32'd0;
    src_b = 32'd0;
  endtask

  // Wait for the done pulse within a bound, then check latency and result.
  task automatic wait_done(input string tag, input int exp_lat,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    while (done !== 1'b1 && cyc < 100) tick();
    check({tag, "_done"}, {63'd0, done}, 64'd1);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_hi"}, {32'd0, hi}, {32'd0, exp_hi});
    check({tag, "_lo"}, {32'd0, lo}, {32'd0, exp_lo});
    check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
    tick();
  endtask

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    op    = 2'b00;
    src_a = 32'd0;
    src_b = 32'd0;
    flush = 1'b0;
    tick();
    tick();
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hi", {32'd0, hi}, 64'd0);
    check("rst_lo", {32'd0, lo}, 64'd0);
    rst = 1'b1;
    tick();

    // MULTU 0xFFFFFFFF * 2 = 0x1_FFFFFFFE
    launch(2'b00, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done("multu", 3, 32'h0000_0001, 32'hFFFF_FFFE);

    // MULT -2 * 3 = -6, busy at T+1 and T+2
    launch(2'b01, 32'hFFFF_FFFE, 32'h0000_0003);
    check("mult_busy_t1", {63'd0, busy}, 64'd1);
    tick();
    check("mult_busy_t2", {63'd0, busy}, 64'd1);
    wait_done("mult", 3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    // MULT -1 * -1 = 1
    launch(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("mult_negneg", 3, 32'h0000_0000, 32'h0000_0001);

    // DIV -7 / 2 -> q=-3, r=-1
    launch(2'b11, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done("div_neg", 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    // DIV 7 / -2 -> q=-3, r=1
    launch(2'b11, 32'h0000_0007, 32'hFFFF_FFFE);
    wait_done("div_negb", 34, 32'h0000_0001, 32'hFFFF_FFFD);

    // DIVU 100 / 0 -> lo=all ones, hi=dividend
    launch(2'b10, 32'd100, 32'd0);
    wait_done("divu_by0", SKIP_LAT, 32'd100, 32'hFFFF_FFFF);

    // DIV -5 / 0 -> hi is the raw dividend with no sign fix
    launch(2'b11, 32'hFFFF_FFFB, 32'd0);
    wait_done("div_by0", SKIP_LAT, 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // DIVU 3 / 10 -> q=0, r=3 (|a|<|b|)
    launch(2'b10, 32'd3, 32'd10);
    wait_done("divu_small", SKIP_LAT, 32'd3, 32'd0);

    // DIV -3 / 10 -> q=0, r=-3
    launch(2'b11, 32'hFFFF_FFFD, 32'd10);
    wait_done("div_small", SKIP_LAT, 32'hFFFF_FFFD, 32'd0);

    // DIVU 0xFFFFFFFF / 1 -> q=0xFFFFFFFF, r=0
    launch(2'b10, 32'hFFFF_FFFF, 32'd1);
    wait_done("divu_max", 34, 32'd0, 32'hFFFF_FFFF);

    // DIV 0x80000000 / -1 -> q=0x80000000, r=0
    launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 34, 32'd0, 32'h8000_0000);

    // DIVU 10/3 flushed at T+10: no done, hi/lo keep the previous result
    launch(2'b10, 32'd10, 32'd3);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_hi", {32'd0, hi}, 64'd0);
    check("flush_lo", {32'd0, lo}, 64'h8000_0000);

    // Start at T+11 is accepted. A second start at T+5 is ignored.
    launch(2'b10, 32'd10, 32'd3);
    repeat (4) tick();
    start = 1'b1;
    op    = 2'b00;
    src_a = 32'd5;
    src_b = 32'd5;
    tick();
    start = 1'b0;
    src_a = 32'd0;
    src_b = 32'd0;
    check("restart_busy", {63'd0, busy}, 64'd1);
    wait_done("divu_10_3", 34, 32'd1, 32'd3);

    // flush and start together: the start is dropped
    start = 1'b1;
    flush = 1'b1;
    op    = 2'b01;
    src_a = 32'd2;
    src_b = 32'd2;
    tick();
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    tick();
    check("flush_start_busy2", {63'd0, busy}, 64'd0);
    check("flush_start_done", {63'd0, done}, 64'd0);

    // Reset in the middle of an operation clears everything
    launch(2'b00, 32'd7, 32'd9);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_hi", {32'd0, hi}, 64'd0);
    check("midrst_lo", {32'd0, lo}, 64'd0);
    repeat (4) tick();
    check("midrst_no_done", {63'd0, done}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
